// File: rtl/mc_control_unit_pkg.sv
// Shared types and constants for the multi-cycle RV32I control unit.
package mc_control_unit_pkg;

    // FSM states of the control unit
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        DECODE  = 3'd2,
        EXECUTE = 3'd3,
        MEM     = 3'd4,
        WB      = 3'd5,
        FAULT   = 3'd6
    } cu_state_t;

    // Instruction format as reported by the decoder
    typedef enum logic [2:0] {
        R_TYPE    = 3'd0,
        I_TYPE    = 3'd1,
        S_TYPE    = 3'd2,
        B_TYPE    = 3'd3,
        U_TYPE    = 3'd4,
        J_TYPE    = 3'd5,
        R4_TYPE   = 3'd6,
        NONE_TYPE = 3'd7
    } instruction_op_type;

    // Branch funct3 encodings
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Opcodes the control unit needs to tell apart
    localparam logic [6:0] LOAD    = 7'b0000011;
    localparam logic [6:0] LOAD_FP = 7'b0000111;
    localparam logic [6:0] U_LUI   = 7'b0110111;

    // True for integer and floating-point loads
    function automatic logic is_load(input logic [6:0] op);
        return (op == LOAD) || (op == LOAD_FP);
    endfunction

endpackage

// File: rtl/mc_control_unit_branch_compare.sv
// Branch condition evaluation: equality plus signed and unsigned less-than.
module branch_compare
    import mc_control_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic            taken
);

    logic eq;
    logic lt_s;
    logic lt_u;

    // Select the branch outcome from the three comparator results
    always_comb begin
        eq   = (rs1_data == rs2_data);
        lt_s = ($signed(rs1_data) < $signed(rs2_data));
        lt_u = (rs1_data < rs2_data);
        unique case (funct3)
            F3_BEQ:  taken = eq;
            F3_BNE:  taken = !eq;
            F3_BLT:  taken = lt_s;
            F3_BGE:  taken = !lt_s;
            F3_BLTU: taken = lt_u;
            F3_BGEU: taken = !lt_u;
            default: taken = 1'b0;   // 010/011 are not branch encodings
        endcase
    end

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle control unit: sequences fetch/decode/execute/mem/write-back,
// handshakes with slow instruction and data memories, and faults on an
// unsupported instruction format or a memory that never acknowledges.
module mc_control_unit
    import mc_control_unit_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [6:0]         opcode,
    input  instruction_op_type optype,
    input  logic [2:0]         funct3,
    input  logic [XLEN-1:0]    rs1_data,
    input  logic [XLEN-1:0]    rs2_data,
    output logic               imem_req,
    input  logic               imem_ack,
    output logic               dmem_req,
    output logic               dmem_we,
    input  logic               dmem_ack,
    output logic               ctrl_ir_load,
    output logic               ctrl_pc_write,
    output logic               ctrl_pc_src,
    output logic               ctrl_reg_write,
    output logic               ctrl_mem2reg,
    output logic               ctrl_alu_src,
    output logic               ctrl_is_branch,
    output logic               ctrl_branch_taken,
    output cu_state_t          cu_state,
    output logic               fault
);

    // Wide enough to count up to MEM_TIMEOUT-1; MEM_TIMEOUT of 0 disables it
    localparam int CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(MEM_TIMEOUT - 1);

    cu_state_t          state;
    cu_state_t          state_next;
    logic [6:0]         opcode_q;
    instruction_op_type optype_q;
    logic [2:0]         funct3_q;
    logic               taken_q;
    logic [CNT_W-1:0]   wait_cnt;
    logic               wait_expired;
    logic               br_taken;

    branch_compare #(.XLEN(XLEN)) u_branch_compare (
        .funct3   (funct3_q),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .taken    (br_taken)
    );

    // State register; reset forces IDLE immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Capture decode fields once so later states see a stable instruction
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opcode_q <= '0;
            optype_q <= R_TYPE;
            funct3_q <= '0;
        end else if (state == DECODE) begin
            opcode_q <= opcode;
            optype_q <= optype;
            funct3_q <= funct3;
        end
    end

    // Remember a jump so write-back can select the jump target
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                     taken_q <= 1'b0;
        else if (state == EXECUTE)   taken_q <= (optype_q == J_TYPE);
    end

    // Memory wait counter: restarts on every state change, counts while stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                   wait_cnt <= '0;
        else if (state_next != state)              wait_cnt <= '0;
        else if (state == FETCH || state == MEM)   wait_cnt <= wait_cnt + 1'b1;
    end

    // Next-state and control decode from the state register and latched fields
    always_comb begin
        state_next        = state;
        imem_req          = 1'b0;
        dmem_req          = 1'b0;
        dmem_we           = 1'b0;
        ctrl_ir_load      = 1'b0;
        ctrl_pc_write     = 1'b0;
        ctrl_pc_src       = 1'b0;
        ctrl_reg_write    = 1'b0;
        ctrl_mem2reg      = 1'b0;
        ctrl_alu_src      = 1'b0;
        ctrl_is_branch    = 1'b0;
        ctrl_branch_taken = 1'b0;
        fault             = 1'b0;
        wait_expired      = (MEM_TIMEOUT != 0) && (wait_cnt == LAST_WAIT);

        unique case (state)
            IDLE: state_next = FETCH;

            FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ctrl_ir_load = 1'b1;
                    state_next   = DECODE;
                end else if (wait_expired) begin
                    state_next = FAULT;
                end
            end

            DECODE: state_next = EXECUTE;

            EXECUTE: begin
                ctrl_alu_src = (optype_q == I_TYPE) || (optype_q == S_TYPE);
                unique case (optype_q)
                    R_TYPE, U_TYPE: state_next = WB;
                    I_TYPE:         state_next = is_load(opcode_q) ? MEM : WB;
                    S_TYPE:         state_next = MEM;
                    J_TYPE: begin
                        ctrl_branch_taken = 1'b1;
                        state_next        = WB;
                    end
                    B_TYPE: begin
                        ctrl_is_branch    = 1'b1;
                        ctrl_branch_taken = br_taken;
                        ctrl_pc_write     = 1'b1;
                        ctrl_pc_src       = br_taken;
                        state_next        = FETCH;
                    end
                    default:        state_next = FAULT;
                endcase
            end

            MEM: begin
                dmem_req     = 1'b1;
                dmem_we      = (optype_q == S_TYPE);
                ctrl_alu_src = (optype_q == I_TYPE) || (optype_q == S_TYPE);
                if (dmem_ack) begin
                    if (optype_q == S_TYPE) begin
                        ctrl_pc_write = 1'b1;   // store finishes here, fall through to PC+4
                        state_next    = FETCH;
                    end else begin
                        state_next = WB;
                    end
                end else if (wait_expired) begin
                    state_next = FAULT;
                end
            end

            WB: begin
                ctrl_reg_write = 1'b1;
                ctrl_mem2reg   = is_load(opcode_q) || (opcode_q == U_LUI);
                ctrl_pc_write  = 1'b1;
                ctrl_pc_src    = taken_q;
                state_next     = FETCH;
            end

            FAULT: begin
                fault      = 1'b1;
                state_next = FAULT;
            end

            default: state_next = FAULT;
        endcase
    end

    assign cu_state = state;

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed bench for mc_control_unit: a table of instructions with expected
// cycle counts and control values, plus reset and fault sequences.
module tb_mc_control_unit;
    import mc_control_unit_pkg::*;

    logic               clk = 1'b0;
    logic               rst;
    logic [6:0]         opcode;
    instruction_op_type optype;
    logic [2:0]         funct3;
    logic [31:0]        rs1_data;
    logic [31:0]        rs2_data;
    logic               imem_req;
    logic               imem_ack;
    logic               dmem_req;
    logic               dmem_we;
    logic               dmem_ack;
    logic               ctrl_ir_load;
    logic               ctrl_pc_write;
    logic               ctrl_pc_src;
    logic               ctrl_reg_write;
    logic               ctrl_mem2reg;
    logic               ctrl_alu_src;
    logic               ctrl_is_branch;
    logic               ctrl_branch_taken;
    cu_state_t          cu_state;
    logic               fault;

    int n_vec = 0;
    int n_err = 0;

    mc_control_unit #(.XLEN(32), .MEM_TIMEOUT(15)) dut (
        .clk               (clk),
        .rst               (rst),
        .opcode            (opcode),
        .optype            (optype),
        .funct3            (funct3),
        .rs1_data          (rs1_data),
        .rs2_data          (rs2_data),
        .imem_req          (imem_req),
        .imem_ack          (imem_ack),
        .dmem_req          (dmem_req),
        .dmem_we           (dmem_we),
        .dmem_ack          (dmem_ack),
        .ctrl_ir_load      (ctrl_ir_load),
        .ctrl_pc_write     (ctrl_pc_write),
        .ctrl_pc_src       (ctrl_pc_src),
        .ctrl_reg_write    (ctrl_reg_write),
        .ctrl_mem2reg      (ctrl_mem2reg),
        .ctrl_alu_src      (ctrl_alu_src),
        .ctrl_is_branch    (ctrl_is_branch),
        .ctrl_branch_taken (ctrl_branch_taken),
        .cu_state          (cu_state),
        .fault             (fault)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        instruction_op_type optype;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [31:0] rs1;
        logic [31:0] rs2;
        int          imem_dly;
        int          dmem_dly;
        int          exp_cycles;
        int          exp_pcw;
        int          exp_rw;
        int          exp_req;
        logic        exp_taken;
        logic        exp_isb;
        logic        exp_pc_src;
        logic        exp_m2r;
        logic        exp_alu;
        logic        exp_we;
        logic        exp_fault;
    } vec_t;

    localparam int NVEC = 17;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [11:0] all_outs();
        return {imem_req, dmem_req, dmem_we, ctrl_ir_load, ctrl_pc_write, ctrl_pc_src,
                ctrl_reg_write, ctrl_mem2reg, ctrl_alu_src, ctrl_is_branch,
                ctrl_branch_taken, fault};
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("reset state", 32'(cu_state), 32'(IDLE));
        check("reset outputs", 32'(all_outs()), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("fetch after reset", 32'(cu_state), 32'(FETCH));
    endtask

    // Runs one instruction from FETCH until the unit returns to FETCH or faults
    task automatic run_vec(input int idx, input vec_t v);
        cu_state_t st;
        cu_state_t prev;
        int   wcnt, cycles, pcw, rw, req;
        logic taken, isb, pc_src, m2r, alu, we, done;
        prev = IDLE; wcnt = 0; cycles = 0; pcw = 0; rw = 0; req = 0;
        taken = 0; isb = 0; pc_src = 0; m2r = 0; alu = 0; we = 0; done = 0;
        opcode = v.opcode; optype = v.optype; funct3 = v.funct3;
        rs1_data = v.rs1; rs2_data = v.rs2;
        while (!done && cycles < 60) begin
            @(negedge clk);
            st = cu_state;
            if (st != prev) wcnt = 0;
            else            wcnt++;
            prev = st;
            imem_ack = (st == FETCH) && (wcnt == v.imem_dly);
            dmem_ack = (st == MEM) && (wcnt == v.dmem_dly);
            #1;
            cycles++;
            if (st == EXECUTE) begin
                taken = ctrl_branch_taken;
                isb   = ctrl_is_branch;
                alu   = ctrl_alu_src;
            end
            if (ctrl_pc_write) begin
                pcw++;
                pc_src = ctrl_pc_src;
            end
            if (ctrl_reg_write) begin
                rw++;
                m2r = ctrl_mem2reg;
            end
            if (st == MEM) begin
                if (dmem_req) req++;
                we = we | dmem_we;
            end
            @(posedge clk);
            #1;
            imem_ack = 1'b0;
            dmem_ack = 1'b0;
            if ((cu_state == FETCH && st != FETCH) || cu_state == FAULT) done = 1'b1;
        end
        check($sformatf("v%0d completed", idx), 32'(done), 32'd1);
        check($sformatf("v%0d cycles", idx), 32'(cycles), 32'(v.exp_cycles));
        check($sformatf("v%0d pc_write count", idx), 32'(pcw), 32'(v.exp_pcw));
        check($sformatf("v%0d reg_write count", idx), 32'(rw), 32'(v.exp_rw));
        check($sformatf("v%0d dmem_req cycles", idx), 32'(req), 32'(v.exp_req));
        check($sformatf("v%0d branch_taken", idx), 32'(taken), 32'(v.exp_taken));
        check($sformatf("v%0d is_branch", idx), 32'(isb), 32'(v.exp_isb));
        check($sformatf("v%0d pc_src", idx), 32'(pc_src), 32'(v.exp_pc_src));
        check($sformatf("v%0d mem2reg", idx), 32'(m2r), 32'(v.exp_m2r));
        check($sformatf("v%0d alu_src", idx), 32'(alu), 32'(v.exp_alu));
        check($sformatf("v%0d dmem_we", idx), 32'(we), 32'(v.exp_we));
        check($sformatf("v%0d fault", idx), 32'(fault), 32'(v.exp_fault));
    endtask

    // Once faulted the unit must ignore acks and stay put until reset
    task automatic check_sticky_fault(input int idx);
        imem_ack = 1'b1;
        dmem_ack = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check($sformatf("v%0d fault sticky state", idx), 32'(cu_state), 32'(FAULT));
        check($sformatf("v%0d fault only output", idx), 32'(all_outs()), 32'h1);
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //            optype     opcode      f3      rs1           rs2    imd dmd cyc pcw rw req tk ib ps m2r alu we flt
        vecs[0]  = '{R_TYPE,    7'b0110011, 3'b000, 32'd1,        32'd2, 0,  0,  4,  1,  1, 0,  0, 0, 0, 0,  0,  0, 0};
        vecs[1]  = '{B_TYPE,    7'b1100011, F3_BLT, 32'hFFFFFFFF, 32'd1, 0,  0,  3,  1,  0, 0,  1, 1, 1, 0,  0,  0, 0};
        vecs[2]  = '{B_TYPE,    7'b1100011, F3_BLTU,32'hFFFFFFFF, 32'd1, 0,  0,  3,  1,  0, 0,  0, 1, 0, 0,  0,  0, 0};
        vecs[3]  = '{B_TYPE,    7'b1100011, F3_BEQ, 32'd5,        32'd5, 0,  0,  3,  1,  0, 0,  1, 1, 1, 0,  0,  0, 0};
        vecs[4]  = '{B_TYPE,    7'b1100011, F3_BNE, 32'd5,        32'd5, 0,  0,  3,  1,  0, 0,  0, 1, 0, 0,  0,  0, 0};
        vecs[5]  = '{B_TYPE,    7'b1100011, F3_BGE, 32'hFFFFFFFF, 32'd1, 0,  0,  3,  1,  0, 0,  0, 1, 0, 0,  0,  0, 0};
        vecs[6]  = '{B_TYPE,    7'b1100011, F3_BGEU,32'hFFFFFFFF, 32'd1, 0,  0,  3,  1,  0, 0,  1, 1, 1, 0,  0,  0, 0};
        vecs[7]  = '{B_TYPE,    7'b1100011, 3'b010, 32'd5,        32'd5, 0,  0,  3,  1,  0, 0,  0, 1, 0, 0,  0,  0, 0};
        vecs[8]  = '{I_TYPE,    LOAD,       3'b010, 32'd0,        32'd0, 0,  3,  8,  1,  1, 4,  0, 0, 0, 1,  1,  0, 0};
        vecs[9]  = '{S_TYPE,    7'b0100011, 3'b010, 32'd0,        32'd0, 0,  0,  4,  1,  0, 1,  0, 0, 0, 0,  1,  1, 0};
        vecs[10] = '{U_TYPE,    U_LUI,      3'b000, 32'd0,        32'd0, 0,  0,  4,  1,  1, 0,  0, 0, 0, 1,  0,  0, 0};
        vecs[11] = '{J_TYPE,    7'b1101111, 3'b000, 32'd0,        32'd0, 0,  0,  4,  1,  1, 0,  1, 0, 1, 0,  0,  0, 0};
        vecs[12] = '{I_TYPE,    7'b0010011, 3'b000, 32'd0,        32'd0, 2,  0,  6,  1,  1, 0,  0, 0, 0, 0,  1,  0, 0};
        vecs[13] = '{S_TYPE,    7'b0100011, 3'b010, 32'd0,        32'd0, 0, 14, 18,  1,  0, 15, 0, 0, 0, 0,  1,  1, 0};
        vecs[14] = '{S_TYPE,    7'b0100011, 3'b010, 32'd0,        32'd0, 0, 99, 18,  0,  0, 15, 0, 0, 0, 0,  1,  1, 1};
        vecs[15] = '{NONE_TYPE, 7'b0000000, 3'b000, 32'd0,        32'd0, 0,  0,  3,  0,  0, 0,  0, 0, 0, 0,  0,  0, 1};
        vecs[16] = '{I_TYPE,    LOAD_FP,    3'b010, 32'd0,        32'd0, 0,  1,  6,  1,  1, 2,  0, 0, 0, 1,  1,  0, 0};

        rst = 1'b1;
        opcode = '0; optype = R_TYPE; funct3 = '0;
        rs1_data = '0; rs2_data = '0;
        imem_ack = 1'b0; dmem_ack = 1'b0;

        #2;
        check("power-on state", 32'(cu_state), 32'(IDLE));
        check("power-on outputs", 32'(all_outs()), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("idle after release", 32'(cu_state), 32'(IDLE));
        @(posedge clk);
        #1;
        check("first fetch", 32'(cu_state), 32'(FETCH));
        check("first fetch imem_req", 32'(imem_req), 32'd1);

        for (int i = 0; i < NVEC; i++) begin
            run_vec(i, vecs[i]);
            if (vecs[i].exp_fault) begin
                check_sticky_fault(i);
                apply_reset();
            end
        end

        // Asynchronous reset while a load waits in MEM
        opcode = LOAD; optype = I_TYPE; funct3 = 3'b010;
        @(negedge clk);
        imem_ack = 1'b1;
        @(posedge clk);
        #1;
        imem_ack = 1'b0;
        check("async seq decode", 32'(cu_state), 32'(DECODE));
        repeat (2) @(posedge clk);
        #1;
        check("async seq mem", 32'(cu_state), 32'(MEM));
        check("async seq dmem_req before rst", 32'(dmem_req), 32'd1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async rst state", 32'(cu_state), 32'(IDLE));
        check("async rst dmem_req", 32'(dmem_req), 32'd0);
        check("async rst outputs", 32'(all_outs()), 32'h0);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("fetch after async rst", 32'(cu_state), 32'(FETCH));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
